// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT sequencer: state codes,
// twiddle constants and the bit-reverse / butterfly-schedule helpers.
package fft8_pkg;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam int C_SQRT2_2 = 23170;
    localparam int C_SHIFT   = 15;

    typedef struct packed {
        logic [2:0] top;
        logic [2:0] bot;
        logic [1:0] k;
    } sched_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Stage s, butterfly b -> in-place addresses and twiddle exponent of W8.
    function automatic sched_t schedule(input logic [1:0] s, input logic [1:0] b);
        sched_t     r;
        logic [2:0] span;
        logic [2:0] pos;
        logic [2:0] top;
        span  = 3'd1 << s;
        pos   = {1'b0, b} & (span - 3'd1);
        top   = (({1'b0, b} >> s) << (s + 2'd1)) + pos;
        r.top = top;
        r.bot = top + span;
        r.k   = 2'(pos << (2'd2 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft8_butterfly.sv
// Combinational radix-2 butterfly with W8^k twiddle, evaluated at WIDTH+1 bits
// and optionally halved on the way out.
module fft8_butterfly
    import fft8_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = 1
) (
    input  logic [WIDTH-1:0] a_re,
    input  logic [WIDTH-1:0] a_im,
    input  logic [WIDTH-1:0] b_re,
    input  logic [WIDTH-1:0] b_im,
    input  logic [1:0]       k,
    output logic [WIDTH-1:0] top_re,
    output logic [WIDTH-1:0] top_im,
    output logic [WIDTH-1:0] bot_re,
    output logic [WIDTH-1:0] bot_im
);

    localparam int  W        = WIDTH + 1;
    localparam int  PW       = W + 16;
    localparam bit  SCALE_ON = (SCALE != 0);

    logic [W-1:0] ar;
    logic [W-1:0] ai;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] wr;
    logic [W-1:0] wi;
    logic [W-1:0] top_re_w;
    logic [W-1:0] top_im_w;
    logic [W-1:0] bot_re_w;
    logic [W-1:0] bot_im_w;

    // The product is wide enough that the kept bits never see the fill bits,
    // so a logical shift here gives the same floored result as an arithmetic one.
    function automatic logic [W-1:0] mul_c(input logic [W-1:0] v);
        logic [PW-1:0] ext;
        ext = {{(PW - W){v[W-1]}}, v};
        return W'((ext * PW'(C_SQRT2_2)) >> C_SHIFT);
    endfunction

    assign ar = {a_re[WIDTH-1], a_re};
    assign ai = {a_im[WIDTH-1], a_im};
    assign x  = {b_re[WIDTH-1], b_re};
    assign y  = {b_im[WIDTH-1], b_im};

    always_comb begin
        wr = x;
        wi = y;
        case (k)
            2'd0: begin
                wr = x;
                wi = y;
            end
            2'd1: begin
                wr = mul_c(x + y);
                wi = mul_c(y - x);
            end
            2'd2: begin
                wr = y;
                wi = -x;
            end
            default: begin
                wr = mul_c(y - x);
                wi = mul_c(-x - y);
            end
        endcase
    end

    assign top_re_w = ar + wr;
    assign top_im_w = ai + wi;
    assign bot_re_w = ar - wr;
    assign bot_im_w = ai - wi;

    assign top_re = WIDTH'(SCALE_ON ? (top_re_w >> 1) : top_re_w);
    assign top_im = WIDTH'(SCALE_ON ? (top_im_w >> 1) : top_im_w);
    assign bot_re = WIDTH'(SCALE_ON ? (bot_re_w >> 1) : bot_re_w);
    assign bot_im = WIDTH'(SCALE_ON ? (bot_im_w >> 1) : bot_im_w);

endmodule

// File: rtl/fft8_seq_ctrl.sv
// 8-point FFT sequencer: serial load into a bit-reversed buffer, 12 in-place
// butterflies on one shared datapath, then natural-order bin streaming.
module fft8_seq_ctrl
    import fft8_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [2:0]       out_idx,
    output logic             busy,
    output logic             frame_done
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [2:0]       in_cnt_q;
    logic [2:0]       in_cnt_d;
    logic [3:0]       run_cnt_q;
    logic [3:0]       run_cnt_d;
    logic [2:0]       out_cnt_q;
    logic [2:0]       out_cnt_d;
    logic             frame_done_q;
    logic             frame_done_d;
    logic [WIDTH-1:0] buf_re_q [8];
    logic [WIDTH-1:0] buf_re_d [8];
    logic [WIDTH-1:0] buf_im_q [8];
    logic [WIDTH-1:0] buf_im_d [8];

    sched_t           sch;
    logic [WIDTH-1:0] bf_top_re;
    logic [WIDTH-1:0] bf_top_im;
    logic [WIDTH-1:0] bf_bot_re;
    logic [WIDTH-1:0] bf_bot_im;

    // Run cycle c maps to stage c/4, butterfly c%4.
    assign sch = schedule(run_cnt_q[3:2], run_cnt_q[1:0]);

    fft8_butterfly #(
        .WIDTH(WIDTH),
        .SCALE(SCALE)
    ) u_butterfly (
        .a_re  (buf_re_q[sch.top]),
        .a_im  (buf_im_q[sch.top]),
        .b_re  (buf_re_q[sch.bot]),
        .b_im  (buf_im_q[sch.bot]),
        .k     (sch.k),
        .top_re(bf_top_re),
        .top_im(bf_top_im),
        .bot_re(bf_bot_re),
        .bot_im(bf_bot_im)
    );

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        run_cnt_d    = run_cnt_q;
        out_cnt_d    = out_cnt_q;
        frame_done_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            buf_re_d[i] = buf_re_q[i];
            buf_im_d[i] = buf_im_q[i];
        end

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    buf_re_d[bitrev3(in_cnt_q)] = in_data;
                    buf_im_d[bitrev3(in_cnt_q)] = '0;
                    in_cnt_d = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'd7) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                buf_re_d[sch.top] = bf_top_re;
                buf_im_d[sch.top] = bf_top_im;
                buf_re_d[sch.bot] = bf_bot_re;
                buf_im_d[sch.bot] = bf_bot_im;
                if (run_cnt_q == 4'd11) begin
                    run_cnt_d = 4'd0;
                    state_d   = ST_OUT;
                end else begin
                    run_cnt_d = run_cnt_q + 4'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d      = ST_LOAD;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            in_cnt_q     <= '0;
            run_cnt_q    <= '0;
            out_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            run_cnt_q    <= run_cnt_d;
            out_cnt_q    <= out_cnt_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 8; i++) begin
                buf_re_q[i] <= buf_re_d[i];
                buf_im_q[i] <= buf_im_d[i];
            end
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_OUT);
    assign busy       = (state_q == ST_RUN) || (state_q == ST_OUT);
    assign out_re     = buf_re_q[out_cnt_q];
    assign out_im     = buf_im_q[out_cnt_q];
    assign out_idx    = out_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Bench for fft8_seq_ctrl: a SCALE=1 and a SCALE=0 instance share one stimulus
// stream and are checked against an integer FFT model with directed and random frames.
module tb_fft8_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_s1, out_valid_s1, busy_s1, frame_done_s1;
    logic [15:0] out_re_s1, out_im_s1;
    logic [2:0]  out_idx_s1;
    logic        in_ready_s0, out_valid_s0, busy_s0, frame_done_s0;
    logic [15:0] out_re_s0, out_im_s0;
    logic [2:0]  out_idx_s0;

    int          n_assert;
    int          n_fail;
    longint      samp [8];
    logic [15:0] exp_re [2][8];
    logic [15:0] exp_im [2][8];
    logic [15:0] got_re [2][8];
    logic [15:0] got_im [2][8];

    fft8_seq_ctrl #(.WIDTH(16), .SCALE(1)) u_dut_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s1),
        .in_data   (in_data),
        .out_valid (out_valid_s1),
        .out_ready (out_ready),
        .out_re    (out_re_s1),
        .out_im    (out_im_s1),
        .out_idx   (out_idx_s1),
        .busy      (busy_s1),
        .frame_done(frame_done_s1)
    );

    fft8_seq_ctrl #(.WIDTH(16), .SCALE(0)) u_dut_s0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s0),
        .in_data   (in_data),
        .out_valid (out_valid_s0),
        .out_ready (out_ready),
        .out_re    (out_re_s0),
        .out_im    (out_im_s0),
        .out_idx   (out_idx_s0),
        .busy      (busy_s0),
        .frame_done(frame_done_s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint m;
        m = v & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1))) m = m - (longint'(1) << n);
        return m;
    endfunction

    function automatic longint cmul(input longint v);
        return wrapn((wrapn(v, 17) * 23170) >>> 15, 17);
    endfunction

    // Textbook DIT FFT on integers: group/offset loops, twiddle by spec rules.
    task automatic computeModel();
        longint re [8];
        longint im [8];
        longint x, y, wr, wi, tr, ti, br, bi;
        int span, bt, t, k;
        for (int sc = 0; sc < 2; sc++) begin
            for (int i = 0; i < 8; i++) begin
                re[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)] = samp[i];
                im[i] = 0;
            end
            for (int s = 0; s < 3; s++) begin
                span = 1 << s;
                for (int g = 0; g < 8; g += 2 * span) begin
                    for (int j = 0; j < span; j++) begin
                        t  = g + j;
                        bt = t + span;
                        k  = j * (4 >> s);
                        x  = re[bt];
                        y  = im[bt];
                        case (k)
                            0:       begin wr = x;            wi = y;            end
                            1:       begin wr = cmul(x + y);  wi = cmul(y - x);  end
                            2:       begin wr = y;            wi = -x;           end
                            default: begin wr = cmul(y - x);  wi = cmul(-x - y); end
                        endcase
                        tr = wrapn(re[t] + wr, 17);
                        ti = wrapn(im[t] + wi, 17);
                        br = wrapn(re[t] - wr, 17);
                        bi = wrapn(im[t] - wi, 17);
                        if (sc == 1) begin
                            tr = tr >>> 1; ti = ti >>> 1; br = br >>> 1; bi = bi >>> 1;
                        end
                        re[t]  = wrapn(tr, 16);
                        im[t]  = wrapn(ti, 16);
                        re[bt] = wrapn(br, 16);
                        im[bt] = wrapn(bi, 16);
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                exp_re[sc][i] = 16'(re[i]);
                exp_im[sc][i] = 16'(im[i]);
            end
        end
    endtask

    // Feeds samp[0..7]; returns right after the edge that accepts the 8th sample.
    task automatic applyStimulus(input bit gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            chk("in_ready_load_s1", 32'(in_ready_s1), 32'd1);
            chk("in_ready_load_s0", 32'(in_ready_s0), 32'd1);
            chk("busy_load_s1", 32'(busy_s1), 32'd0);
            chk("out_valid_load_s0", 32'(out_valid_s0), 32'd0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = samp[i][15:0];
            end
            @(posedge clk);
            if (in_valid) i++;
        end
        if (i < 8) chk("load_timeout", 32'(i), 32'd8);
    endtask

    // RUN window: junk on the input must be ignored, no output for 12 cycles.
    task automatic checkLatency();
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk("run_out_valid_s1", 32'(out_valid_s1), 32'd0);
            chk("run_out_valid_s0", 32'(out_valid_s0), 32'd0);
            chk("run_in_ready_s1", 32'(in_ready_s1), 32'd0);
            chk("run_busy_s0", 32'(busy_s0), 32'd1);
            in_valid = (n < 12);
            in_data  = 16'($urandom);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic checkOutput(input int mode);
        int transfers;
        int cyc;
        transfers = 0;
        cyc = 0;
        while (transfers < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("out_valid_s1", 32'(out_valid_s1), 32'd1);
            chk("out_valid_s0", 32'(out_valid_s0), 32'd1);
            chk("out_idx_s1", 32'(out_idx_s1), 32'(transfers));
            chk("out_idx_s0", 32'(out_idx_s0), 32'(transfers));
            chk("out_re_s1", 32'(out_re_s1), 32'(exp_re[1][transfers]));
            chk("out_im_s1", 32'(out_im_s1), 32'(exp_im[1][transfers]));
            chk("out_re_s0", 32'(out_re_s0), 32'(exp_re[0][transfers]));
            chk("out_im_s0", 32'(out_im_s0), 32'(exp_im[0][transfers]));
            chk("out_in_ready_s1", 32'(in_ready_s1), 32'd0);
            chk("out_busy_s1", 32'(busy_s1), 32'd1);
            chk("out_frame_done_s1", 32'(frame_done_s1), 32'd0);
            got_re[1][transfers] = out_re_s1;
            got_im[1][transfers] = out_im_s1;
            got_re[0][transfers] = out_re_s0;
            got_im[0][transfers] = out_im_s0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) transfers++;
        end
        if (transfers < 8) chk("out_timeout", 32'(transfers), 32'd8);
        @(negedge clk);
        out_ready = 1'b0;
        chk("frame_done_s1", 32'(frame_done_s1), 32'd1);
        chk("frame_done_s0", 32'(frame_done_s0), 32'd1);
        chk("done_out_valid_s1", 32'(out_valid_s1), 32'd0);
        chk("done_in_ready_s0", 32'(in_ready_s0), 32'd1);
        chk("done_busy_s1", 32'(busy_s1), 32'd0);
        @(negedge clk);
        chk("frame_done_pulse_s1", 32'(frame_done_s1), 32'd0);
        chk("frame_done_pulse_s0", 32'(frame_done_s0), 32'd0);
    endtask

    task automatic runFrame(input int mode, input bit gaps);
        computeModel();
        applyStimulus(gaps);
        checkLatency();
        checkOutput(mode);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready_s1", 32'(in_ready_s1), 32'd1);
        chk("rst_out_valid_s1", 32'(out_valid_s1), 32'd0);
        chk("rst_busy_s0", 32'(busy_s0), 32'd0);
        chk("rst_frame_done_s1", 32'(frame_done_s1), 32'd0);
        chk("rst_out_re_s1", 32'(out_re_s1), 32'd0);
        chk("rst_out_idx_s0", 32'(out_idx_s0), 32'd0);
        rst = 1'b0;

        $display("[TB] impulse");
        foreach (samp[i]) samp[i] = 0;
        samp[0] = 1024;
        runFrame(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("impulse_re_s1", 32'(got_re[1][i]), 32'd128);
            chk("impulse_im_s1", 32'(got_im[1][i]), 32'd0);
            chk("impulse_re_s0", 32'(got_re[0][i]), 32'd1024);
        end

        $display("[TB] dc");
        foreach (samp[i]) samp[i] = 1024;
        runFrame(0, 1'b0);
        chk("dc_bin0_s1", 32'(got_re[1][0]), 32'd1024);
        for (int i = 1; i < 8; i++) chk("dc_bin_zero_s1", 32'(got_re[1][i]), 32'd0);

        $display("[TB] alternating");
        foreach (samp[i]) samp[i] = (i % 2 == 0) ? 1024 : -1024;
        runFrame(0, 1'b1);
        chk("alt_bin4_s1", 32'(got_re[1][4]), 32'd1024);
        chk("alt_bin0_s1", 32'(got_re[1][0]), 32'd0);

        $display("[TB] cosine");
        samp[0] = 1024;  samp[1] = 724;   samp[2] = 0;  samp[3] = -724;
        samp[4] = -1024; samp[5] = -724;  samp[6] = 0;  samp[7] = 724;
        runFrame(2, 1'b1);

        $display("[TB] impulse with backpressure");
        foreach (samp[i]) samp[i] = 0;
        samp[0] = 1024;
        runFrame(1, 1'b0);

        $display("[TB] reset during run");
        foreach (samp[i]) samp[i] = wrapn(longint'($urandom_range(0, 65535)), 16);
        applyStimulus(1'b0);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid_s1", 32'(out_valid_s1), 32'd0);
        chk("midrst_busy_s1", 32'(busy_s1), 32'd0);
        chk("midrst_in_ready_s0", 32'(in_ready_s0), 32'd1);
        @(negedge clk);
        chk("midrst_next_out_valid_s0", 32'(out_valid_s0), 32'd0);
        chk("midrst_next_busy_s0", 32'(busy_s0), 32'd0);
        chk("midrst_next_in_ready_s1", 32'(in_ready_s1), 32'd1);
        rst = 1'b0;
        foreach (samp[i]) samp[i] = 1024;
        runFrame(0, 1'b0);
        chk("post_rst_dc_bin0_s1", 32'(got_re[1][0]), 32'd1024);

        $display("[TB] wrap with SCALE=0");
        foreach (samp[i]) samp[i] = 8192;
        runFrame(0, 1'b0);
        chk("wrap_bin0_s0", 32'(got_re[0][0]), 32'd0);
        chk("wrap_bin0_s1", 32'(got_re[1][0]), 32'd8192);

        $display("[TB] random frames");
        for (int f = 0; f < 5; f++) begin
            foreach (samp[i]) samp[i] = wrapn(longint'($urandom_range(0, 65535)), 16);
            runFrame(2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
